// File: rtl/sqrt_fp_param.sv
// sqrt_fp_param: parametrised IEEE-754 binary square root (fp16/bf16/fp32 via EXP_W/MAN_W).
// Streaming valid/ready on both sides, one operation in flight, radix-2 restoring core,
// round-to-nearest-even.
// Optional: define SQRT_INEXACT_EN to add the IS_INEXACT output.
module sqrt_fp_param #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [EXP_W+MAN_W:0]   IN_DATA,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [EXP_W+MAN_W:0]   OUT_DATA,
   output logic                   IS_NAN,
   output logic                   IS_PINF,
   output logic                   IS_NINF
`ifdef SQRT_INEXACT_EN
   ,
   output logic                   IS_INEXACT
`endif
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int BIAS  = 2**(EXP_W-1) - 1;
   localparam int ITERS = MAN_W + 2;
   localparam int RAD_W = 2 * ITERS;
   localparam int REM_W = ITERS + 2;
   localparam int CNT_W = $clog2(ITERS);
   localparam int LZ_W  = $clog2(MAN_W + 2);

   localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_ITER,
      S_ROUND,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       op_q;
   logic [RAD_W-1:0]   rad_q;
   logic [REM_W-1:0]   rem_q;
   logic [ITERS-1:0]   root_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [EXP_W-1:0]   exp_q;
   logic [W-1:0]       out_data_q;
   logic               nan_q;
   logic               pinf_q;
`ifdef SQRT_INEXACT_EN
   logic               inx_q;
`endif

   // operand classification
   logic               op_sign;
   logic [EXP_W-1:0]   op_exp;
   logic [MAN_W-1:0]   op_frac;
   logic               exp_ones, exp_zero, frac_zero;
   logic               in_nan, in_pinf, in_zero;

   // normalisation
   logic [MAN_W:0]     sig, nsig;
   logic [LZ_W-1:0]    lz;
   logic               lz_found;
   logic [EXP_W-1:0]   e_eff;
   logic [EXP_W:0]     e_sum;
   logic [RAD_W-1:0]   rad_init;

   // iteration step
   logic [REM_W-1:0]   rem_sh, trial, rem_nx;
   logic               take;
   logic [ITERS-1:0]   root_nx;

   // rounding
   logic               guard, sticky, rnd_up;
   logic [MAN_W:0]     frac_sum;
   logic [EXP_W-1:0]   res_exp;
   logic [W-1:0]       rounded;

   assign op_sign   = op_q[W-1];
   assign op_exp    = op_q[W-2:MAN_W];
   assign op_frac   = op_q[MAN_W-1:0];
   assign exp_ones  = &op_exp;
   assign exp_zero  = ~|op_exp;
   assign frac_zero = ~|op_frac;
   assign in_nan    = (exp_ones & ~frac_zero) | (op_sign & ~(exp_zero & frac_zero));
   assign in_pinf   = exp_ones & frac_zero & ~op_sign;
   assign in_zero   = exp_zero & frac_zero;

   assign sig = {~exp_zero, op_frac};

   // leading-zero count of the significand (hidden bit included)
   always_comb begin
      lz       = '0;
      lz_found = 1'b0;
      for (int unsigned i = 0; i <= MAN_W; i++) begin
         if (!lz_found && sig[MAN_W-i]) begin
            lz       = LZ_W'(i);
            lz_found = 1'b1;
         end
      end
   end

   // Biased result exponent is floor((E_eff - lz + BIAS)/2); its parity equals the
   // parity of the unbiased exponent, so bit 0 selects the extra significand shift.
   assign nsig     = sig << lz;
   assign e_eff    = exp_zero ? EXP_W'(1) : op_exp;
   assign e_sum    = {1'b0, e_eff} + (EXP_W+1)'(BIAS) - (EXP_W+1)'(lz);
   assign rad_init = e_sum[0] ? {nsig, 1'b0, {(MAN_W+2){1'b0}}}
                              : {1'b0, nsig, {(MAN_W+2){1'b0}}};

   assign rem_sh  = {rem_q[ITERS-1:0], rad_q[RAD_W-1 -: 2]};
   assign trial   = {root_q, 2'b01};
   assign take    = (rem_sh >= trial);
   assign rem_nx  = take ? (rem_sh - trial) : rem_sh;
   assign root_nx = {root_q[ITERS-2:0], take};

   assign guard    = root_q[0];
   assign sticky   = |rem_q;
   assign rnd_up   = guard & (sticky | root_q[1]);
   assign frac_sum = {1'b0, root_q[ITERS-2:1]} + {{MAN_W{1'b0}}, rnd_up};
   assign res_exp  = exp_q + {{(EXP_W-1){1'b0}}, frac_sum[MAN_W]};
   assign rounded  = {1'b0, res_exp, frac_sum[MAN_W-1:0]};

   assign IN_READY  = (state_q == S_IDLE);
   assign OUT_VALID = (state_q == S_DONE);
   assign OUT_DATA  = out_data_q;
   assign IS_NAN    = nan_q;
   assign IS_PINF   = pinf_q;
   assign IS_NINF   = 1'b0;
`ifdef SQRT_INEXACT_EN
   assign IS_INEXACT = inx_q;
`endif

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (IN_VALID) state_d = S_NORM;
         S_NORM:  state_d = (in_nan || in_pinf || in_zero) ? S_DONE : S_ITER;
         S_ITER:  if (cnt_q == CNT_W'(ITERS-1)) state_d = S_ROUND;
         S_ROUND: state_d = S_DONE;
         S_DONE:  if (OUT_READY) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // operand capture, root iteration, rounding and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q       <= '0;
         rad_q      <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         exp_q      <= '0;
         out_data_q <= '0;
         nan_q      <= 1'b0;
         pinf_q     <= 1'b0;
`ifdef SQRT_INEXACT_EN
         inx_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (IN_VALID) op_q <= IN_DATA;
            end
            S_NORM: begin
               if (in_nan) begin
                  out_data_q <= QNAN;
                  nan_q      <= 1'b1;
               end else if (in_pinf || in_zero) begin
                  out_data_q <= op_q;
                  pinf_q     <= in_pinf;
               end else begin
                  rad_q  <= rad_init;
                  rem_q  <= '0;
                  root_q <= '0;
                  cnt_q  <= '0;
                  exp_q  <= e_sum[EXP_W:1];
               end
`ifdef SQRT_INEXACT_EN
               inx_q <= 1'b0;
`endif
            end
            S_ITER: begin
               rad_q  <= rad_q << 2;
               rem_q  <= rem_nx;
               root_q <= root_nx;
               cnt_q  <= (cnt_q == CNT_W'(ITERS-1)) ? '0 : cnt_q + 1'b1;
            end
            S_ROUND: begin
               out_data_q <= rounded;
               nan_q      <= 1'b0;
               pinf_q     <= 1'b0;
`ifdef SQRT_INEXACT_EN
               inx_q      <= guard | sticky;
`endif
            end
            S_DONE: begin
               if (OUT_READY) begin
                  nan_q  <= 1'b0;
                  pinf_q <= 1'b0;
`ifdef SQRT_INEXACT_EN
                  inx_q  <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_fp_param.sv
// Testbench for sqrt_fp_param: fp16 (default) and fp32 instances, directed vectors,
// real-arithmetic reference model, per-cycle output comparison.
module tb_sqrt_fp_param;

   logic        clk;
   logic        rst_n;

   logic        v16_in, r16_in, v16_out, r16_out;
   logic [15:0] d16_in, d16_out;
   logic        nan16, pinf16, ninf16;
   logic        v32_in, r32_in, v32_out, r32_out;
   logic [31:0] d32_in, d32_out;
   logic        nan32, pinf32, ninf32;
`ifdef SQRT_INEXACT_EN
   logic        inx16, inx32;
`endif

   int nvec = 0;
   int nmis = 0;

   logic [15:0] e16_d;
   bit          e16_nan, e16_pinf, e16_inx, pend16;
   logic [31:0] e32_d;
   bit          e32_nan, e32_pinf, e32_inx, pend32;

   sqrt_fp_param u_fp16 (
      .CLK(clk), .RST_N(rst_n),
      .IN_VALID(v16_in), .IN_READY(r16_in), .IN_DATA(d16_in),
      .OUT_VALID(v16_out), .OUT_READY(r16_out), .OUT_DATA(d16_out),
      .IS_NAN(nan16), .IS_PINF(pinf16), .IS_NINF(ninf16)
`ifdef SQRT_INEXACT_EN
      , .IS_INEXACT(inx16)
`endif
   );

   sqrt_fp_param #(.EXP_W(8), .MAN_W(23)) u_fp32 (
      .CLK(clk), .RST_N(rst_n),
      .IN_VALID(v32_in), .IN_READY(r32_in), .IN_DATA(d32_in),
      .OUT_VALID(v32_out), .OUT_READY(r32_out), .OUT_DATA(d32_out),
      .IS_NAN(nan32), .IS_PINF(pinf32), .IS_NINF(ninf32)
`ifdef SQRT_INEXACT_EN
      , .IS_INEXACT(inx32)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   function automatic real p2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: decode to a real, take the real square root, re-encode with
   // round-to-nearest-even; inexact when the rounded result does not square back.
   function automatic logic [31:0] model(input logic [31:0] x, input int ew, input int mw,
                                         output bit nan, output bit pinf, output bit inx);
      longint xv, one, bias, emax, sgn, e, f, q, res;
      real    v, r, y, sc, d, yr;
      int     k;
      one  = 1;
      xv   = longint'(x);
      bias = (one << (ew-1)) - 1;
      emax = (one << ew) - 1;
      sgn  = (xv >> (ew+mw)) & 1;
      e    = (xv >> mw) & emax;
      f    = xv & ((one << mw) - 1);
      nan = 0; pinf = 0; inx = 0;
      if ((e == emax && f != 0) || (sgn == 1 && (e != 0 || f != 0))) begin
         res = (one << (ew+mw)) | (emax << mw) | (one << (mw-1));
         nan = 1;
      end else if (e == emax) begin
         res  = xv;
         pinf = 1;
      end else if (e == 0 && f == 0) begin
         res = xv;
      end else begin
         if (e == 0) v = real'(f) * p2(int'(1 - bias - mw));
         else        v = real'(f + (one << mw)) * p2(int'(e - bias - mw));
         r = $sqrt(v);
         y = r; k = 0;
         while (y >= 2.0) begin y = y / 2.0; k++; end
         while (y < 1.0)  begin y = y * 2.0; k--; end
         sc = y * p2(mw);
         q  = longint'($rtoi(sc));
         d  = sc - real'(q);
         if (d > 0.5 || (d == 0.5 && (q & 1) == 1)) q++;
         if (q == (one << (mw+1))) begin q = q >> 1; k++; end
         yr  = real'(q) * p2(k - mw);
         inx = (yr * yr != v);
         res = ((longint'(k) + bias) << mw) | (q - (one << mw));
      end
      return 32'(res);
   endfunction

   // output comparison against the current expectation on every valid cycle
   always @(negedge clk) begin
      if (rst_n && v16_out) begin
         chk("fp16 valid while expected", {31'b0, pend16}, 32'd1);
         chk("fp16 OUT_DATA", {16'b0, d16_out}, {16'b0, e16_d});
         chk("fp16 IS_NAN", {31'b0, nan16}, {31'b0, e16_nan});
         chk("fp16 IS_PINF", {31'b0, pinf16}, {31'b0, e16_pinf});
         chk("fp16 IS_NINF", {31'b0, ninf16}, 32'd0);
`ifdef SQRT_INEXACT_EN
         chk("fp16 IS_INEXACT", {31'b0, inx16}, {31'b0, e16_inx});
`endif
      end
      if (rst_n && v32_out) begin
         chk("fp32 valid while expected", {31'b0, pend32}, 32'd1);
         chk("fp32 OUT_DATA", d32_out, e32_d);
         chk("fp32 IS_NAN", {31'b0, nan32}, {31'b0, e32_nan});
         chk("fp32 IS_PINF", {31'b0, pinf32}, {31'b0, e32_pinf});
         chk("fp32 IS_NINF", {31'b0, ninf32}, 32'd0);
`ifdef SQRT_INEXACT_EN
         chk("fp32 IS_INEXACT", {31'b0, inx32}, {31'b0, e32_inx});
`endif
      end
   end

   task automatic set16(input logic [15:0] x, input logic [15:0] lit, input logic [1:0] lflags);
      bit n, p, i;
      logic [31:0] m;
      m = model({16'b0, x}, 5, 10, n, p, i);
      chk($sformatf("fp16 model %h", x), m, {16'b0, lit});
      chk($sformatf("fp16 model flags %h", x), {30'b0, n, p}, {30'b0, lflags});
      e16_d = m[15:0]; e16_nan = n; e16_pinf = p; e16_inx = i; pend16 = 1;
   endtask

   task automatic wait16(input int lat_req);
      int lat;
      lat = 0;
      do begin @(posedge clk); lat++; #1; end while (!v16_out && lat < 200);
      chk("fp16 latency", lat, lat_req);
      if (r16_out) begin
         @(posedge clk); #1;
         pend16 = 0;
         chk("fp16 IN_READY after transfer", {31'b0, r16_in}, 32'd1);
         chk("fp16 OUT_VALID after transfer", {31'b0, v16_out}, 32'd0);
      end
   endtask

   task automatic op16(input logic [15:0] x, input logic [15:0] lit, input logic [1:0] lflags,
                       input int lat_req);
      set16(x, lit, lflags);
      @(negedge clk);
      chk("fp16 IN_READY idle", {31'b0, r16_in}, 32'd1);
      d16_in = x; v16_in = 1'b1;
      @(posedge clk); #1;
      v16_in = 1'b0; d16_in = '0;
      wait16(lat_req);
   endtask

   task automatic op32(input logic [31:0] x, input logic [31:0] lit, input logic [1:0] lflags,
                       input int lat_req);
      bit n, p, i;
      logic [31:0] m;
      int lat;
      m = model(x, 8, 23, n, p, i);
      chk($sformatf("fp32 model %h", x), m, lit);
      chk($sformatf("fp32 model flags %h", x), {30'b0, n, p}, {30'b0, lflags});
      e32_d = m; e32_nan = n; e32_pinf = p; e32_inx = i; pend32 = 1;
      @(negedge clk);
      chk("fp32 IN_READY idle", {31'b0, r32_in}, 32'd1);
      d32_in = x; v32_in = 1'b1;
      @(posedge clk); #1;
      v32_in = 1'b0; d32_in = '0;
      lat = 0;
      do begin @(posedge clk); lat++; #1; end while (!v32_out && lat < 200);
      chk("fp32 latency", lat, lat_req);
      @(posedge clk); #1;
      pend32 = 0;
      chk("fp32 IN_READY after transfer", {31'b0, r32_in}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      bit n, p, i;
      logic [31:0] m;
      rst_n = 1'b0;
      v16_in = 1'b0; d16_in = '0; r16_out = 1'b1;
      v32_in = 1'b0; d32_in = '0; r32_out = 1'b1;
      pend16 = 0; pend32 = 0;
      e16_d = '0; e16_nan = 0; e16_pinf = 0; e16_inx = 0;
      e32_d = '0; e32_nan = 0; e32_pinf = 0; e32_inx = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset IN_READY", {31'b0, r16_in}, 32'd1);
      chk("reset OUT_VALID", {31'b0, v16_out}, 32'd0);
      chk("reset OUT_DATA", {16'b0, d16_out}, 32'd0);
      chk("reset flags", {29'b0, nan16, pinf16, ninf16}, 32'd0);
      chk("reset fp32 OUT_DATA", d32_out, 32'd0);
`ifdef SQRT_INEXACT_EN
      chk("reset IS_INEXACT", {31'b0, inx16}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // pin the model's inexact decision
      m = model(32'h4000, 5, 10, n, p, i);
      chk("model inexact 4000", {31'b0, i}, 32'd1);
      m = model(32'h4400, 5, 10, n, p, i);
      chk("model inexact 4400", {31'b0, i}, 32'd0);

      // normal, subnormal, signed zero
      op16(16'h7BFF, 16'h5BFF, 2'b00, 14);
      op16(16'h0001, 16'h0C00, 2'b00, 14);
      op16(16'h0002, 16'h0DA8, 2'b00, 14);
      op16(16'h4880, 16'h4200, 2'b00, 14);
      op16(16'h8000, 16'h8000, 2'b00, 1);
      op16(16'h0000, 16'h0000, 2'b00, 1);
      op16(16'h4000, 16'h3DA8, 2'b00, 14);
      // specials
      op16(16'h7C00, 16'h7C00, 2'b01, 1);
      op16(16'hFC00, 16'hFE00, 2'b10, 1);
      op16(16'hBC00, 16'hFE00, 2'b10, 1);
      op16(16'h7D00, 16'hFE00, 2'b10, 1);

      // backpressure: result held, new operand held off then processed
      r16_out = 1'b0;
      op16(16'h4400, 16'h4000, 2'b00, 14);
      @(negedge clk);
      d16_in = 16'h3C00; v16_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp IN_READY", {31'b0, r16_in}, 32'd0);
         chk("bp OUT_VALID", {31'b0, v16_out}, 32'd1);
         chk("bp OUT_DATA", {16'b0, d16_out}, 32'h4000);
      end
      @(negedge clk);
      r16_out = 1'b1;
      @(posedge clk); #1;
      pend16 = 0;
      chk("bp IN_READY after release", {31'b0, r16_in}, 32'd1);
      chk("bp OUT_VALID after release", {31'b0, v16_out}, 32'd0);
      set16(16'h3C00, 16'h3C00, 2'b00);
      @(posedge clk); #1;
      v16_in = 1'b0; d16_in = '0;
      wait16(14);

      // reset during iteration
      set16(16'h4000, 16'h3DA8, 2'b00);
      @(negedge clk);
      d16_in = 16'h4000; v16_in = 1'b1;
      @(posedge clk); #1;
      v16_in = 1'b0; d16_in = '0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      pend16 = 0;
      chk("mid reset IN_READY", {31'b0, r16_in}, 32'd1);
      chk("mid reset OUT_VALID", {31'b0, v16_out}, 32'd0);
      chk("mid reset OUT_DATA", {16'b0, d16_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op16(16'h3800, 16'h39A8, 2'b00, 14);

      // fp32 instance
      op32(32'h40800000, 32'h40000000, 2'b00, 27);
      op32(32'h40000000, 32'h3FB504F3, 2'b00, 27);
      op32(32'hFF800000, 32'hFFC00000, 2'b10, 1);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
